busca_binaria: RTL

BUSCA_BINARIA -- requirements
Module: busca_binaria

---
 rtl/busca_binaria.sv | 134 +++++++++++++
 1 files changed

// File: rtl/busca_binaria.sv
// Successive-approximation (binary) search controller.
// Drives a trial value to an external comparator and refines it one bit per
// cycle from the MSB down, using the maior/igual/menor flags that come back.
module busca_binaria #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iniciar,
    input  logic             maior,
    input  logic             igual,
    input  logic             menor,
    output logic [WIDTH-1:0] palpite,
    output logic [WIDTH-1:0] resultado,
    output logic             ocupado,
    output logic             pronto,
    output logic             erro
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        BUSCA  = 2'd1,
        FIM    = 2'd2
    } estado_t;

    estado_t          state_reg, state_next;
    logic [IW-1:0]    idx_reg, idx_next;
    logic [WIDTH-1:0] palpite_reg, palpite_next;
    logic [WIDTH-1:0] resultado_reg, resultado_next;
    logic             ocupado_reg, ocupado_next;
    logic             pronto_reg, pronto_next;
    logic             erro_reg, erro_next;

    // Trial value with the current bit cleared (used when the guess was too big)
    logic [WIDTH-1:0] trial;
    // Number of comparator flags asserted; anything but one is a fault
    logic [1:0]       flag_count;

    assign flag_count = {1'b0, maior} + {1'b0, igual} + {1'b0, menor};

    assign palpite   = palpite_reg;
    assign resultado = resultado_reg;
    assign ocupado   = ocupado_reg;
    assign pronto    = pronto_reg;
    assign erro      = erro_reg;

    // State and datapath registers; reset abandons any search in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= OCIOSO;
            idx_reg       <= IW'(WIDTH - 1);
            palpite_reg   <= '0;
            resultado_reg <= '0;
            ocupado_reg   <= 1'b0;
            pronto_reg    <= 1'b0;
            erro_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            palpite_reg   <= palpite_next;
            resultado_reg <= resultado_next;
            ocupado_reg   <= ocupado_next;
            pronto_reg    <= pronto_next;
            erro_reg      <= erro_next;
        end
    end

    // Next-state and next-output logic; outputs are registered so ocupado and
    // pronto line up exactly with the BUSCA and FIM states
    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        palpite_next   = palpite_reg;
        resultado_next = resultado_reg;
        erro_next      = erro_reg;
        ocupado_next   = 1'b0;
        pronto_next    = 1'b0;
        trial          = palpite_reg;
        trial[idx_reg] = 1'b0;

        case (state_reg)
            OCIOSO: begin
                if (iniciar) begin
                    palpite_next = WIDTH'(1) << (WIDTH - 1);
                    idx_next     = IW'(WIDTH - 1);
                    erro_next    = 1'b0;
                    ocupado_next = 1'b1;
                    state_next   = BUSCA;
                end
            end
            BUSCA: begin
                ocupado_next = 1'b1;
                if (flag_count != 2'd1) begin
                    erro_next      = 1'b1;
                    resultado_next = palpite_reg;
                    state_next     = FIM;
                end else if (igual) begin
                    resultado_next = palpite_reg;
                    state_next     = FIM;
                end else if (maior) begin
                    palpite_next = trial;
                    if (idx_reg != '0) begin
                        palpite_next[idx_reg - 1'b1] = 1'b1;
                        idx_next = idx_reg - 1'b1;
                    end else begin
                        resultado_next = trial;
                        state_next     = FIM;
                    end
                end else begin
                    if (idx_reg != '0) begin
                        palpite_next[idx_reg - 1'b1] = 1'b1;
                        idx_next = idx_reg - 1'b1;
                    end else begin
                        resultado_next = palpite_reg;
                        state_next     = FIM;
                    end
                end
                if (state_next == FIM) begin
                    ocupado_next = 1'b0;
                    pronto_next  = 1'b1;
                end
            end
            FIM: begin
                state_next = OCIOSO;
            end
            default: begin
                state_next = OCIOSO;
            end
        endcase
    end

endmodule
